// File: rtl/tx_iq_fifo_if.sv
// I/Q sample stream from the TX core, DAC-side outputs and status of the tx_iq_fifo block.
// The slave modport is the FIFO; the master modport is whatever drives the core/DAC side.
interface tx_iq_fifo_if #(
  parameter int DEPTH = 64
) ();
  localparam int AW = $clog2(DEPTH);

  logic          result_iq_valid;
  logic [15:0]   result_i;
  logic [15:0]   result_q;
  logic          result_iq_hold;
  logic          phy_tx_done;
  logic          dac_strobe;
  logic          dac_valid;
  logic [15:0]   dac_i;
  logic [15:0]   dac_q;
  logic          iq_drained;
  logic          underflow;
  logic          overflow;
  logic          clr_status;
  logic [AW:0]   fill_level;

  modport master (
    output result_iq_valid, result_i, result_q, phy_tx_done, dac_strobe, clr_status,
    input  result_iq_hold, dac_valid, dac_i, dac_q, iq_drained, underflow, overflow, fill_level
  );

  modport slave (
    input  result_iq_valid, result_i, result_q, phy_tx_done, dac_strobe, clr_status,
    output result_iq_hold, dac_valid, dac_i, dac_q, iq_drained, underflow, overflow, fill_level
  );
endinterface

// File: rtl/tx_iq_fifo.sv
// I/Q buffer between OFDM TX core and DAC: prefills, then pops one sample per dac_strobe (1 clk strobe->dac_valid).
// Backpressure: registered result_iq_hold once occupancy reaches DEPTH-HOLD_MARGIN; pushes while full are dropped.
module tx_iq_fifo #(
  parameter int DEPTH       = 64,
  parameter int HOLD_MARGIN = 4,
  parameter int START_LEVEL = 16
) (
  input  logic        clk,
  input  logic        rstn,
  tx_iq_fifo_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] HOLD_L  = (AW+1)'(DEPTH - HOLD_MARGIN);
  localparam logic [AW:0] START_L = (AW+1)'(START_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_STREAM  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        hold_q, hold_d;
  logic        dac_valid_q, dac_valid_d;
  logic [15:0] dac_i_q, dac_i_d;
  logic [15:0] dac_q_q, dac_q_d;
  logic        drained_q, drained_d;
  logic        underflow_q, underflow_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] head;
  logic [AW:0] count;
  logic [AW:0] count_d;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        uf_set;
  logic        of_set;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_L);
  assign empty = (count == '0);
  assign push  = io.result_iq_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    dac_valid_d = 1'b0;
    dac_i_d     = dac_i_q;
    dac_q_d     = dac_q_q;
    drained_d   = 1'b0;
    uf_set      = 1'b0;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        if (push) begin
          state_d = S_PREFILL;
        end
      end
      S_PREFILL: begin
        if (io.phy_tx_done) begin
          done_d = 1'b1;
        end
        // A short packet that ends before START_LEVEL still has to play out.
        if ((count >= START_L) || done_q || io.phy_tx_done) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (io.phy_tx_done) begin
          done_d = 1'b1;
        end
        if (empty && done_q) begin
          state_d   = S_IDLE;
          drained_d = 1'b1;
          dac_i_d   = '0;
          dac_q_d   = '0;
          done_d    = 1'b0;
        end else if (io.dac_strobe) begin
          dac_valid_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            dac_i_d = head[31:16];
            dac_q_d = head[15:0];
          end else begin
            dac_i_d = '0;
            dac_q_d = '0;
            uf_set  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    of_set      = io.result_iq_valid && full;
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d     = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    hold_d      = (count_d >= HOLD_L);
    // A fresh error in the same cycle as clr_status must survive the clear.
    underflow_d = uf_set || (underflow_q && !io.clr_status);
    overflow_d  = of_set || (overflow_q && !io.clr_status);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_i_q     <= '0;
      dac_q_q     <= '0;
      drained_q   <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hold_q      <= hold_d;
      dac_valid_q <= dac_valid_d;
      dac_i_q     <= dac_i_d;
      dac_q_q     <= dac_q_d;
      drained_q   <= drained_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {io.result_i, io.result_q};
    end
  end

  assign io.result_iq_hold = hold_q;
  assign io.dac_valid      = dac_valid_q;
  assign io.dac_i          = dac_i_q;
  assign io.dac_q          = dac_q_q;
  assign io.iq_drained     = drained_q;
  assign io.underflow      = underflow_q;
  assign io.overflow       = overflow_q;
  assign io.fill_level     = count;

endmodule

// File: tb/tb_tx_iq_fifo.sv
// Bench for tx_iq_fifo: hand-computed vector table, directed corner sequences, and random traffic
// checked every cycle against a queue-based reference model.
module tb_tx_iq_fifo;
  localparam int DEPTH       = 64;
  localparam int HOLD_MARGIN = 4;
  localparam int START_LEVEL = 16;
  localparam int AW          = 6;

  logic clk;
  logic rstn;

  tx_iq_fifo_if #(.DEPTH(DEPTH)) bus ();

  tx_iq_fifo #(
    .DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN), .START_LEVEL(START_LEVEL)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of {i,q} words plus a coarse play-out mode.
  typedef enum int {M_IDLE, M_PRE, M_STREAM} mmode_t;
  logic [31:0] mq[$];
  mmode_t      m_mode;
  bit          m_done;
  bit          e_hold, e_dv, e_dr, e_uf, e_of;
  logic [15:0] e_di, e_dq;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] dut_all();
    return {20'd0, bus.result_iq_hold, bus.dac_valid, bus.dac_i, bus.dac_q,
            bus.iq_drained, bus.underflow, bus.overflow, bus.fill_level};
  endfunction

  function automatic logic [63:0] model_all();
    logic [AW:0] f;
    f = (AW+1)'(mq.size());
    return {20'd0, e_hold, e_dv, e_di, e_dq, e_dr, e_uf, e_of, f};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE; m_done = 0;
    e_hold = 0; e_dv = 0; e_dr = 0; e_uf = 0; e_of = 0; e_di = 0; e_dq = 0;
  endtask

  task automatic model_edge();
    int n;
    bit push, uf_set, of_set, old_done;
    logic [31:0] head;
    if (!rstn) begin
      model_reset();
      return;
    end
    n        = mq.size();
    push     = bus.result_iq_valid && (n < DEPTH);
    of_set   = bus.result_iq_valid && (n == DEPTH);
    uf_set   = 0;
    old_done = m_done;
    e_dv = 0; e_dr = 0;
    case (m_mode)
      M_IDLE: if (push) m_mode = M_PRE;
      M_PRE: begin
        if (bus.phy_tx_done) m_done = 1;
        if (n >= START_LEVEL || m_done) m_mode = M_STREAM;
      end
      M_STREAM: begin
        if (n == 0 && old_done) begin
          m_mode = M_IDLE; m_done = 0; e_dr = 1; e_di = 0; e_dq = 0;
        end else begin
          if (bus.phy_tx_done) m_done = 1;
          if (bus.dac_strobe) begin
            e_dv = 1;
            if (n > 0) begin
              head = mq.pop_front();
              e_di = head[31:16]; e_dq = head[15:0];
            end else begin
              e_di = 0; e_dq = 0; uf_set = 1;
            end
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    if (push) mq.push_back({bus.result_i, bus.result_q});
    e_hold = (mq.size() >= DEPTH - HOLD_MARGIN);
    e_uf = uf_set || (e_uf && !bus.clr_status);
    e_of = of_set || (e_of && !bus.clr_status);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("model", dut_all(), model_all());
  endtask

  task automatic clr_in();
    bus.result_iq_valid = 0; bus.result_i = 0; bus.result_q = 0;
    bus.phy_tx_done = 0; bus.dac_strobe = 0; bus.clr_status = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    model_reset();
    #1;
    check("reset_async_zero", dut_all(), 64'd0);
    repeat (3) cycle();
    rstn = 1;
  endtask

  typedef struct {
    bit          v;
    logic [15:0] i;
    bit          done, stb, clr;
    bit          x_hold, x_dv;
    logic [15:0] x_di;
    bit          x_dr, x_uf;
    logic [AW:0] x_fill;
  } vec_t;

  function automatic vec_t mk(input bit v, input int i, input bit done, input bit stb, input bit clr,
                              input bit xh, input bit xdv, input int xdi, input bit xdr,
                              input bit xuf, input int xf);
    vec_t r;
    r.v = v; r.i = 16'(i); r.done = done; r.stb = stb; r.clr = clr;
    r.x_hold = xh; r.x_dv = xdv; r.x_di = 16'(xdi); r.x_dr = xdr; r.x_uf = xuf;
    r.x_fill = (AW+1)'(xf);
    return r;
  endfunction

  vec_t tbl[12];

  initial begin
    int k, early, drains, dvs, mism, max_fill, prev_fill;
    bit seen60, seen_fall, done_pend;
    int to_send;
    logic [15:0] got[$];

    // Short packet: three pushes (one strobe ignored in prefill), done, play-out, drain.
    tbl[0]  = mk(1, 10, 0, 0, 0,  0, 0,  0, 0, 0, 1);
    tbl[1]  = mk(1, 11, 0, 0, 0,  0, 0,  0, 0, 0, 2);
    tbl[2]  = mk(1, 12, 0, 1, 0,  0, 0,  0, 0, 0, 3);
    tbl[3]  = mk(0,  0, 1, 0, 0,  0, 0,  0, 0, 0, 3);
    tbl[4]  = mk(0,  0, 0, 1, 0,  0, 1, 10, 0, 0, 2);
    tbl[5]  = mk(0,  0, 0, 0, 0,  0, 0, 10, 0, 0, 2);
    tbl[6]  = mk(0,  0, 0, 1, 0,  0, 1, 11, 0, 0, 1);
    tbl[7]  = mk(0,  0, 0, 1, 0,  0, 1, 12, 0, 0, 0);
    tbl[8]  = mk(0,  0, 0, 0, 0,  0, 0,  0, 1, 0, 0);
    tbl[9]  = mk(0,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
    tbl[10] = mk(0,  0, 0, 1, 0,  0, 0,  0, 0, 0, 0);
    tbl[11] = mk(1, 20, 0, 0, 1,  0, 0,  0, 0, 0, 1);

    // Reset with valid and strobe held high.
    clr_in();
    bus.result_iq_valid = 1; bus.dac_strobe = 1; bus.result_i = 16'h1234; bus.result_q = 16'h5678;
    do_reset();
    bus.dac_strobe = 0;
    cycle();
    check("first_push_fill", 64'(bus.fill_level), 64'd1);
    bus.result_iq_valid = 0;
    bus.dac_strobe = 1;
    cycle();
    check("prefill_no_dv", 64'(bus.dac_valid), 64'd0);
    clr_in();

    // Vector table.
    do_reset();
    for (int t = 0; t < 12; t++) begin
      bus.result_iq_valid = tbl[t].v; bus.result_i = tbl[t].i; bus.result_q = -tbl[t].i;
      bus.phy_tx_done = tbl[t].done; bus.dac_strobe = tbl[t].stb; bus.clr_status = tbl[t].clr;
      cycle();
      check($sformatf("vec%0d", t),
            {37'd0, bus.result_iq_hold, bus.dac_valid, bus.dac_i, bus.iq_drained, bus.underflow, bus.fill_level},
            {37'd0, tbl[t].x_hold, tbl[t].x_dv, tbl[t].x_di, tbl[t].x_dr, tbl[t].x_uf, tbl[t].x_fill});
    end
    clr_in();

    // 24 samples i=k, q=-k, strobe every 5 clk, late pushes overlap pops.
    do_reset();
    k = 0; early = 0; drains = 0; got.delete();
    for (int c = 0; c < 200; c++) begin
      bus.result_iq_valid = (k < 16) || (k < 24 && c >= 20 && c % 5 == 4);
      bus.result_i = 16'(k); bus.result_q = 16'(-k);
      bus.dac_strobe  = (c % 5 == 4);
      bus.phy_tx_done = (c == 70);
      cycle();
      if (bus.result_iq_valid) k++;
      if (bus.dac_valid) begin
        if (k < 16) early++;
        got.push_back(bus.dac_i);
      end
      if (bus.iq_drained) drains++;
      if (c == 24) check("simul_push_pop_fill", 64'(bus.fill_level), 64'd15);
    end
    mism = 0;
    foreach (got[j]) if (got[j] != 16'(j)) mism++;
    check("stream_early_dv", 64'(early), 64'd0);
    check("stream_count", 64'(got.size()), 64'd24);
    check("stream_order_mism", 64'(mism), 64'd0);
    check("stream_drains", 64'(drains), 64'd1);
    check("stream_no_uf", 64'(bus.underflow), 64'd0);
    clr_in();

    // Hold threshold with a compliant upstream pushing whenever not held.
    do_reset();
    max_fill = 0; prev_fill = 0; seen60 = 0; seen_fall = 0; drains = 0;
    for (int c = 0; c < 140; c++) begin
      bus.result_iq_valid = !bus.result_iq_hold;
      bus.result_i = 16'(c); bus.result_q = 16'(~c);
      bus.dac_strobe = (c % 5 == 4);
      cycle();
      if (int'(bus.fill_level) > max_fill) max_fill = int'(bus.fill_level);
      if (bus.fill_level == 60 && !seen60) begin
        seen60 = 1;
        check("hold_at_60", 64'(bus.result_iq_hold), 64'd1);
      end
      if (prev_fill == 60 && bus.fill_level == 59 && !seen_fall) begin
        seen_fall = 1;
        check("hold_falls_59", 64'(bus.result_iq_hold), 64'd0);
      end
      prev_fill = int'(bus.fill_level);
    end
    check("hold_fall_seen", 64'(seen_fall), 64'd1);
    check("hold_max_fill", 64'(max_fill), 64'd60);
    check("hold_no_ovf", 64'(bus.overflow), 64'd0);
    bus.result_iq_valid = 0;
    bus.dac_strobe = 0; bus.phy_tx_done = 1;
    cycle();
    bus.phy_tx_done = 0;
    for (int c = 0; c < 400 && drains == 0; c++) begin
      bus.dac_strobe = (c % 5 == 4);
      cycle();
      if (bus.iq_drained) drains++;
    end
    check("hold_drained", 64'(drains), 64'd1);
    clr_in();

    // Five samples then done: below START_LEVEL, still plays out.
    do_reset();
    dvs = 0; drains = 0;
    for (int c = 0; c < 5; c++) begin
      bus.result_iq_valid = 1; bus.result_i = 16'(100 + c); bus.result_q = 16'(c);
      cycle();
    end
    bus.result_iq_valid = 0; bus.phy_tx_done = 1;
    cycle();
    bus.phy_tx_done = 0;
    for (int c = 0; c < 60; c++) begin
      bus.dac_strobe = (c % 5 == 4);
      cycle();
      if (bus.dac_valid) dvs++;
      if (bus.iq_drained) drains++;
    end
    check("short_dv_count", 64'(dvs), 64'd5);
    check("short_drains", 64'(drains), 64'd1);
    check("short_no_uf", 64'(bus.underflow), 64'd0);
    check("short_fill", 64'(bus.fill_level), 64'd0);
    clr_in();

    // Underflow: 20 samples, no done, keep strobing.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.result_iq_valid = 1; bus.result_i = 16'(c); bus.result_q = 16'(c + 1);
      cycle();
    end
    bus.result_iq_valid = 0;
    for (int s = 0; s < 21; s++) begin
      bus.dac_strobe = 1;
      cycle();
      bus.dac_strobe = 0;
      if (s == 19) check("uf_last_sample", {47'd0, bus.underflow, bus.dac_i}, {47'd0, 1'b0, 16'd19});
      if (s == 20) check("uf_strobe", {30'd0, bus.dac_valid, bus.dac_i, bus.dac_q, bus.underflow},
                         {30'd0, 1'b1, 16'd0, 16'd0, 1'b1});
      repeat (4) cycle();
    end
    bus.clr_status = 1;
    cycle();
    bus.clr_status = 0;
    check("uf_cleared", 64'(bus.underflow), 64'd0);
    bus.clr_status = 1; bus.dac_strobe = 1;
    cycle();
    bus.clr_status = 0; bus.dac_strobe = 0;
    check("uf_set_wins", 64'(bus.underflow), 64'd1);
    bus.phy_tx_done = 1;
    cycle();
    bus.phy_tx_done = 0;
    drains = 0;
    repeat (3) begin
      cycle();
      if (bus.iq_drained) drains++;
    end
    check("uf_done_drain", 64'(drains), 64'd1);
    clr_in();

    // Overflow: hold ignored until the 65th sample.
    do_reset();
    for (int c = 0; c < 65; c++) begin
      bus.result_iq_valid = 1; bus.result_i = 16'(c); bus.result_q = 16'(-c);
      cycle();
      if (c == 63) check("ovf_before", {56'd0, bus.overflow, bus.fill_level}, {56'd0, 1'b0, 7'd64});
    end
    check("ovf_after", {56'd0, bus.overflow, bus.fill_level}, {56'd0, 1'b1, 7'd64});
    bus.result_iq_valid = 0;
    got.delete();
    for (int c = 0; c < 50; c++) begin
      bus.dac_strobe = (c % 5 == 4);
      cycle();
      if (bus.dac_valid) got.push_back(bus.dac_i);
    end
    mism = 0;
    foreach (got[j]) if (got[j] != 16'(j)) mism++;
    check("ovf_order", {32'(got.size()), 32'(mism)}, {32'd10, 32'd0});
    bus.dac_strobe = 0;
    rstn = 0;
    model_reset();
    #1;
    check("rst_mid_zero", dut_all(), 64'd0);
    repeat (2) cycle();
    rstn = 1;
    bus.dac_strobe = 1;
    cycle();
    bus.dac_strobe = 0;
    check("rst_idle_no_dv", 64'(bus.dac_valid), 64'd0);
    bus.result_iq_valid = 1; bus.result_i = 16'h7fff; bus.result_q = 16'h8000;
    cycle();
    check("rst_then_push", 64'(bus.fill_level), 64'd1);
    clr_in();

    // Random traffic against the model.
    do_reset();
    to_send = 0; done_pend = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        clr_in();
        do_reset();
        to_send = 0; done_pend = 0;
      end
      bus.phy_tx_done = 0;
      if (to_send == 0 && !done_pend && $urandom_range(0, 60) == 0) begin
        to_send = int'($urandom_range(1, 80)); done_pend = 1;
      end
      if (to_send == 0 && done_pend && $urandom_range(0, 3) == 0) begin
        bus.phy_tx_done = 1; done_pend = 0;
      end
      bus.result_iq_valid = (to_send > 0) && ($urandom_range(0, 3) != 0) &&
                            (!bus.result_iq_hold || $urandom_range(0, 29) == 0);
      bus.result_i = 16'($urandom); bus.result_q = 16'($urandom);
      if (bus.result_iq_valid) to_send--;
      bus.dac_strobe = (c % 5 == 2) || ($urandom_range(0, 40) == 0);
      bus.clr_status = ($urandom_range(0, 50) == 0);
      cycle();
    end
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_iq_fifo.md
# tx_iq_fifo

- Downstream stage of the OFDM TX core.
- Buffers the core's 16-bit I/Q samples in a small FIFO and throttles the core through `result_iq_hold`.
- Releases samples toward the DAC/RF interface, one per `dac_strobe` pulse: the sample-rate tick, e.g. every 5th clk for 20 MSPS at 100 MHz.
- Prefills before streaming so packets do not underrun mid-frame.
- Reports drain completion, underflow and overflow.

## Interface
Parameters:
- `DEPTH`, 64: FIFO entries. Power of two, ≥8.
- `HOLD_MARGIN`, 4: hold asserts when fill ≥ DEPTH−HOLD_MARGIN. Range ≥2.
- `START_LEVEL`, 16: fill required before streaming begins. Range 1..DEPTH−HOLD_MARGIN.

Ports (AW = log2(DEPTH)):
- `clk` in 1: single clock for the whole block.
- `rstn` in 1: asynchronous, active-low reset.
- `result_iq_valid` in 1: upstream sample valid.
- `result_i`, `result_q` in 16 each: upstream sample, two's complement.
- `result_iq_hold` out 1: backpressure to the TX core (core ready = ~hold).
- `phy_tx_done` in 1: one-cycle pulse; the last upstream sample has been issued.
- `dac_strobe` in 1: one-cycle sample-rate tick.
- `dac_valid` out 1: one-cycle pulse; `dac_i`/`dac_q` updated.
- `dac_i`, `dac_q` out 16 each: sample toward the DAC, held between strobes.
- `iq_drained` out 1: one-cycle pulse; packet fully played out.
- `underflow` out 1: sticky; strobe hit an empty FIFO mid-packet.
- `overflow` out 1: sticky; a valid sample arrived while the FIFO was full.
- `clr_status` in 1: synchronous clear of `underflow`/`overflow`.
- `fill_level` out AW+1: current FIFO occupancy.

## Operation
- Storage: DEPTH × 32-bit array holding {i,q}.
  - Read/write pointers are AW+1 bits; wrap-around is natural binary.
  - full = count==DEPTH; empty = count==0.
- Push: `result_iq_valid` && !full. Valid while full: sample dropped, `overflow` set.
- Pop: only in STREAM, on `dac_strobe` && !empty.
- Push and pop in the same cycle: count unchanged.
- `result_iq_hold` is a register: hold <= (count_next ≥ DEPTH−HOLD_MARGIN). It deasserts when count_next drops below the threshold.
- `done_seen` is sticky, set by `phy_tx_done` in PREFILL or STREAM, cleared on entry to IDLE.
- FSM:
  - IDLE: outputs idle, `dac_i`/`dac_q` = 0. A push → PREFILL. `phy_tx_done` ignored here.
  - PREFILL: no pops; strobes ignored. count ≥ START_LEVEL, or done_seen (or `phy_tx_done` this cycle) → STREAM.
  - STREAM, strobe with data: pop; `dac_i`/`dac_q` <= head; `dac_valid` pulses.
  - STREAM, strobe while empty and !done_seen: `dac_i`/`dac_q` <= 0, `dac_valid` pulses, `underflow` set.
  - STREAM, empty && done_seen (no strobe needed): → IDLE, `iq_drained` pulses, `dac_i`/`dac_q` <= 0.
- `clr_status` and a new error in the same cycle: the set wins.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE.
  - `result_iq_hold` = 0, `fill_level` = 0, `underflow` = `overflow` = 0, done_seen = 0.
- Push at edge n: `fill_level` and `result_iq_hold` reflect it after edge n (same edge).
- Strobe sampled at edge n: `dac_valid`/`dac_i`/`dac_q` update at edge n; visible cycle n+1, latency 1.
- The core may issue one more sample after hold rises. HOLD_MARGIN ≥ 2 guarantees no overflow with a compliant upstream.
- `iq_drained` fires the cycle after the last pop's `dac_valid`, unless done arrives later.
- Reset mid-packet: FIFO contents discarded, FSM to IDLE immediately, no `iq_drained` pulse.

## Test plan
- Reset with valid=1 and strobe=1 held: all outputs 0 during reset. After release, the first push gives `fill_level`=1 and state PREFILL.
- Push 16 samples (i=k, q=−k) with strobe every 5 clk:
  - no `dac_valid` until fill=16;
  - then `dac_i`=0,1,2… in order, each one cycle after its strobe;
  - `fill_level` correct through simultaneous push/pop.
- Upstream pushes every cycle ignoring nothing, DEPTH=64: hold rises when fill reaches 60 and falls below 60 as the DAC drains; `overflow` stays 0.
- Push 5 samples then `phy_tx_done` (< START_LEVEL): STREAM begins at done, 5 samples play, `iq_drained` pulses once, state IDLE, no underflow.
- Push 20 samples, no done, keep strobing: after the 20th sample, the next strobe gives `dac_valid`=1, `dac_i`=`dac_q`=0, `underflow`=1.
  - `clr_status` clears it.
  - `clr_status` coincident with another underflow strobe leaves it 1.
- Force valid with hold ignored until full: the 65th sample is dropped, `overflow`=1, FIFO order intact. Deassert `rstn` mid-stream: immediate empty/IDLE, outputs 0.
